arb2in1_ctrl: RTL and testbench
===============================

Name: arb2in1_ctrl

Overview:
- Two-requester round-robin arbiter and sequencer for the shared 32-bit 2:1 datapath mux.
- Drives the mux select (o_control) and captures the selected word into a single-entry output register with a valid/ready handshake.
- Sits between two producers (e.g. fetch path and load/store path) and one shared consumer.
- Sustains one transfer per cycle when the consumer is always ready.

Parameters:
- DATA_W, 32, width of data words.
- PRIO_INIT, 0, requester favoured on the first contention after reset (0 or 1).

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_req0  input  1  requester 0 has valid data on i_dat0.
- i_dat0  input  DATA_W  requester 0 data.
- o_ack0  output  1  requester 0 word accepted this edge (combinational).
- i_req1  input  1  requester 1 has valid data on i_dat1.
- i_dat1  input  DATA_W  requester 1 data.
- o_ack1  output  1  requester 1 word accepted this edge (combinational).
- o_control  output  1  mux select for the current cycle: 0 = dat0, 1 = dat1 (combinational).
- o_valid  output  1  output register holds a word.
- o_dat  output  DATA_W  registered output word.
- o_src  output  1  requester ID of o_dat.
- i_ready  input  1  consumer accepts o_dat this edge.

Behaviour:
- Reset (async, i_rst_n=0): o_valid=0, o_dat=0, o_src=0, last-grant pointer = ~PRIO_INIT. o_ack0/o_ack1 are forced to 0 while reset is asserted.
- can_load = !o_valid || i_ready. The register is empty or drains on this edge.
- Arbitration (combinational):
  - Only req0 asserted: select 0.
  - Only req1 asserted: select 1.
  - Both asserted: select ~last_gnt.
  - Neither asserted: o_control holds last_gnt.
- o_ackX = can_load && i_reqX && (o_control==X). At most one ack is high in any cycle.
- Load edge (ack high):
  - o_dat <= selected data, o_src <= o_control, o_valid <= 1, last_gnt <= o_control.
  - Latency: request to o_valid is 1 cycle.
- Drain edge (o_valid && i_ready with no ack): o_valid <= 0. o_dat and o_src hold their values.
- Simultaneous drain and load: the new word replaces the old one and o_valid stays 1. This gives full throughput.
- Stall (o_valid && !i_ready):
  - Both acks are 0.
  - o_dat, o_src and o_valid are stable.
  - last_gnt is unchanged, so a waiting requester keeps its round-robin turn.
- Requesters hold i_reqX and i_datX stable until they see o_ackX. Deasserting a request without an ack is legal; the word is simply not taken.
- Fairness: under continuous contention with i_ready=1, grants alternate 0,1,0,1… No requester waits more than 1 transfer slot.
- Reset mid-transfer: any pending o_dat is discarded and the pointer returns to its reset value.

Optional Feature:
- Macro ARB2_STATS_EN.
- Defined:
  - Adds outputs o_cnt0 and o_cnt1, 16 bits each, counting accepted words per requester (increment on o_ackX).
  - Counters saturate at 16'hFFFF and clear on reset.
  - Adds output o_stall, 1 bit: registered flag, set for the cycle after any cycle in which a request was pending but no ack was given.
- Undefined: these ports and their logic are absent. Core behaviour is identical.

Test Plan:
- Reset then idle:
  - Stimulus: i_rst_n=0 then 1, no requests, i_ready=1.
  - Required: o_valid=0, o_dat=0, o_src=0, acks=0 throughout.
- Single requester:
  - Stimulus: i_req0=1, i_dat0=32'h1234_5678 for 1 cycle, i_ready=1.
  - Required: o_ack0=1 that cycle; next cycle o_valid=1, o_dat=32'h1234_5678, o_src=0, o_control=0; o_valid falls the cycle after.
- Contention, PRIO_INIT=0:
  - Stimulus: both requests held, i_dat0=32'h1234_5678, i_dat1=32'hFFEE_AABB, i_ready=1, four transfers.
  - Required: o_dat sequence 1234_5678, FFEE_AABB, 1234_5678, FFEE_AABB with o_src 0,1,0,1.
- Back-pressure:
  - Stimulus: o_valid=1 holding FFEE_AABB, i_ready=0 for 3 cycles, req0 pending.
  - Required: o_ack0=0 and o_dat stable for all 3 cycles; on the i_ready=1 edge, o_ack0=1 and o_dat becomes the requester-0 word in the same edge.
- Reset mid-operation:
  - Stimulus: o_valid=1, then assert i_rst_n=0 between clock edges.
  - Required: o_valid=0 and o_dat=0 immediately, without waiting for a clock edge.
- Stats (ARB2_STATS_EN defined):
  - Stimulus: 5 accepted words from requester 1 and 2 from requester 0.
  - Required: o_cnt1=5, o_cnt0=2; o_stall pulses in the cycle after each stalled request.

Source files
------------

// File: rtl/arb2in1_ctrl.sv
// Two-requester round-robin arbiter feeding a single-entry valid/ready output register.
// Optional per-requester statistics (o_cnt0, o_cnt1, o_stall) are built when ARB2_STATS_EN is defined.
module arb2in1_ctrl #(
  parameter int unsigned DATA_W    = 32,
  parameter bit          PRIO_INIT = 1'b0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req0,
  input  logic [DATA_W-1:0] i_dat0,
  output logic              o_ack0,
  input  logic              i_req1,
  input  logic [DATA_W-1:0] i_dat1,
  output logic              o_ack1,
  output logic              o_control,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_dat,
  output logic              o_src,
  input  logic              i_ready
`ifdef ARB2_STATS_EN
  ,
  output logic [15:0]       o_cnt0,
  output logic [15:0]       o_cnt1,
  output logic              o_stall
`endif
);

  logic              last_gnt_q, last_gnt_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] dat_q, dat_d;
  logic              src_q, src_d;
  logic              can_load, sel, load;

`ifdef ARB2_STATS_EN
  logic [15:0] cnt0_q, cnt0_d;
  logic [15:0] cnt1_q, cnt1_d;
  logic        stall_q, stall_d;
`endif

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    sel = last_gnt_q;
    unique case ({i_req1, i_req0})
      2'b01:   sel = 1'b0;
      2'b10:   sel = 1'b1;
      2'b11:   sel = ~last_gnt_q;
      default: sel = last_gnt_q;
    endcase

    can_load = !valid_q || i_ready;
    // Acks are held low while reset is asserted so no producer retires a word that is being discarded.
    o_ack0 = i_rst_n && can_load && i_req0 && (sel == 1'b0);
    o_ack1 = i_rst_n && can_load && i_req1 && (sel == 1'b1);
    load   = o_ack0 || o_ack1;

    last_gnt_d = last_gnt_q;
    valid_d    = valid_q;
    dat_d      = dat_q;
    src_d      = src_q;
    if (load) begin
      // A load on a draining edge overwrites the old word, which is what gives full throughput.
      last_gnt_d = sel;
      valid_d    = 1'b1;
      dat_d      = sel ? i_dat1 : i_dat0;
      src_d      = sel;
    end else if (valid_q && i_ready) begin
      valid_d = 1'b0;
    end

`ifdef ARB2_STATS_EN
    cnt0_d  = (o_ack0 && cnt0_q != 16'hFFFF) ? cnt0_q + 16'd1 : cnt0_q;
    cnt1_d  = (o_ack1 && cnt1_q != 16'hFFFF) ? cnt1_q + 16'd1 : cnt1_q;
    stall_d = (i_req0 || i_req1) && !load;
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      last_gnt_q <= ~PRIO_INIT;
      valid_q    <= 1'b0;
      dat_q      <= '0;
      src_q      <= 1'b0;
`ifdef ARB2_STATS_EN
      cnt0_q     <= '0;
      cnt1_q     <= '0;
      stall_q    <= 1'b0;
`endif
    end else begin
      last_gnt_q <= last_gnt_d;
      valid_q    <= valid_d;
      dat_q      <= dat_d;
      src_q      <= src_d;
`ifdef ARB2_STATS_EN
      cnt0_q     <= cnt0_d;
      cnt1_q     <= cnt1_d;
      stall_q    <= stall_d;
`endif
    end
  end

  assign o_control = sel;
  assign o_valid   = valid_q;
  assign o_dat     = dat_q;
  assign o_src     = src_q;

`ifdef ARB2_STATS_EN
  assign o_cnt0  = cnt0_q;
  assign o_cnt1  = cnt1_q;
  assign o_stall = stall_q;
`endif

endmodule

// File: tb/tb_arb2in1_ctrl.sv
// Self-checking bench for arb2in1_ctrl: directed scenarios plus randomized traffic against a
// transaction-level model of the arbiter. Stats checks are active when ARB2_STATS_EN is defined.
module tb_arb2in1_ctrl;
  localparam int DATA_W = 32;
  localparam bit PRIO_INIT = 1'b0;

  logic              i_clk = 1'b0;
  logic              i_rst_n = 1'b0;
  logic              i_req0 = 1'b0, i_req1 = 1'b0;
  logic [DATA_W-1:0] i_dat0 = '0, i_dat1 = '0;
  logic              o_ack0, o_ack1, o_control, o_valid, o_src;
  logic [DATA_W-1:0] o_dat;
  logic              i_ready = 1'b1;
`ifdef ARB2_STATS_EN
  logic [15:0]       o_cnt0, o_cnt1;
  logic              o_stall;
`endif

  arb2in1_ctrl #(.DATA_W(DATA_W), .PRIO_INIT(PRIO_INIT)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_req0(i_req0), .i_dat0(i_dat0), .o_ack0(o_ack0),
    .i_req1(i_req1), .i_dat1(i_dat1), .o_ack1(o_ack1),
    .o_control(o_control), .o_valid(o_valid), .o_dat(o_dat), .o_src(o_src),
    .i_ready(i_ready)
`ifdef ARB2_STATS_EN
    , .o_cnt0(o_cnt0), .o_cnt1(o_cnt1), .o_stall(o_stall)
`endif
  );

  always #5 i_clk = ~i_clk;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: the word held for the consumer, and whose turn it is on a tie.
  bit              m_valid;
  bit [DATA_W-1:0] m_word;
  int              m_src;
  int              m_turn;        // requester that wins the next tie
  int              m_cnt [2];
  bit              m_stall;

  task automatic model_reset();
    m_valid = 0; m_word = '0; m_src = 0;
    m_turn = PRIO_INIT ? 1 : 0;
    m_cnt[0] = 0; m_cnt[1] = 0; m_stall = 0;
  endtask

  initial model_reset();

  always @(negedge i_clk) begin
    int  winner;
    bit  room, e_ack0, e_ack1;
    if (!i_rst_n) begin
      model_reset();
      check("rst_valid", 64'(o_valid), 64'(0));
      check("rst_dat", 64'(o_dat), 64'(0));
      check("rst_ack", 64'({o_ack1, o_ack0}), 64'(0));
    end else begin
      // Idle mux points at the most recent winner, i.e. the one whose turn it is not.
      if (i_req0 && i_req1)  winner = m_turn;
      else if (i_req0)       winner = 0;
      else if (i_req1)       winner = 1;
      else                   winner = 1 - m_turn;
      room   = !m_valid || i_ready;
      e_ack0 = room && i_req0 && winner == 0;
      e_ack1 = room && i_req1 && winner == 1;

      check("m_control", 64'(o_control), 64'(winner));
      check("m_ack0", 64'(o_ack0), 64'(e_ack0));
      check("m_ack1", 64'(o_ack1), 64'(e_ack1));
      check("m_valid", 64'(o_valid), 64'(m_valid));
      if (m_valid) begin
        check("m_dat", 64'(o_dat), 64'(m_word));
        check("m_src", 64'(o_src), 64'(m_src));
      end
`ifdef ARB2_STATS_EN
      check("m_cnt0", 64'(o_cnt0), 64'(m_cnt[0]));
      check("m_cnt1", 64'(o_cnt1), 64'(m_cnt[1]));
      check("m_stall", 64'(o_stall), 64'(m_stall));
`endif
      m_stall = (i_req0 || i_req1) && !(e_ack0 || e_ack1);
      if (e_ack0 || e_ack1) begin
        m_word  = winner == 1 ? i_dat1 : i_dat0;
        m_src   = winner;
        m_valid = 1;
        m_turn  = 1 - winner;
        if (m_cnt[winner] < 16'hFFFF) m_cnt[winner]++;
      end else if (m_valid && i_ready) begin
        m_valid = 0;
      end
    end
  end

  task automatic step();
    @(posedge i_clk); #1;
  endtask

  task automatic do_reset();
    step(); i_rst_n = 1'b0; i_req0 = 0; i_req1 = 0; i_ready = 1;
    step(); step(); i_rst_n = 1'b1;
  endtask

  logic [DATA_W-1:0] exp_seq [4];
  logic [3:0]        exp_src;
  bit                a0, a1, rst_pending;

  initial begin
    // Reset then idle.
    i_rst_n = 1'b0;
    step(); step(); i_rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      check("idle_valid", 64'(o_valid), 64'(0));
      check("idle_dat", 64'(o_dat), 64'(0));
      check("idle_src", 64'(o_src), 64'(0));
      check("idle_acks", 64'({o_ack1, o_ack0}), 64'(0));
    end

    // Single requester.
    step(); i_req0 = 1; i_dat0 = 32'h1234_5678;
    @(negedge i_clk);
    check("single_ack0", 64'(o_ack0), 64'(1));
    step(); i_req0 = 0;
    @(negedge i_clk);
    check("single_valid", 64'(o_valid), 64'(1));
    check("single_dat", 64'(o_dat), 64'h1234_5678);
    check("single_src", 64'(o_src), 64'(0));
    check("single_ctrl", 64'(o_control), 64'(0));
    step();
    @(negedge i_clk);
    check("single_drain", 64'(o_valid), 64'(0));

    // Contention from a fresh reset: requester 0 wins first, then strict alternation.
    do_reset();
    exp_seq[0] = 32'h1234_5678; exp_seq[1] = 32'hFFEE_AABB;
    exp_seq[2] = 32'h1234_5678; exp_seq[3] = 32'hFFEE_AABB;
    exp_src = 4'b1010;
    i_req0 = 1; i_dat0 = 32'h1234_5678; i_req1 = 1; i_dat1 = 32'hFFEE_AABB;
    for (int k = 0; k < 4; k++) begin
      step();
      if (k == 3) begin i_req1 = 0; i_ready = 0; end
      @(negedge i_clk);
      check("cont_dat", 64'(o_dat), 64'(exp_seq[k]));
      check("cont_src", 64'(o_src), 64'(exp_src[k]));
    end

    // Back-pressure: FFEE_AABB held, req0 waiting for 3 cycles.
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge i_clk);
      check("bp_ack0", 64'(o_ack0), 64'(0));
      check("bp_dat", 64'(o_dat), 64'hFFEE_AABB);
      check("bp_valid", 64'(o_valid), 64'(1));
      if (k < 2) step();
    end
    step(); i_ready = 1;
    @(negedge i_clk);
    check("bp_release_ack0", 64'(o_ack0), 64'(1));
    step(); i_req0 = 0; i_ready = 0;
    @(negedge i_clk);
    check("bp_new_dat", 64'(o_dat), 64'h1234_5678);
    check("bp_new_src", 64'(o_src), 64'(0));

    // Asynchronous reset between edges clears the held word immediately.
    step(); #2;
    i_rst_n = 1'b0; #1;
    check("arst_valid", 64'(o_valid), 64'(0));
    check("arst_dat", 64'(o_dat), 64'(0));
    check("arst_acks", 64'({o_ack1, o_ack0}), 64'(0));
    step(); i_rst_n = 1'b1; i_ready = 1;

`ifdef ARB2_STATS_EN
    // Five words from requester 1, then two from requester 0, one stalled cycle in between.
    do_reset();
    i_req1 = 1;
    for (int k = 0; k < 5; k++) begin i_dat1 = 32'(k); step(); end
    i_req1 = 0; i_req0 = 1; i_ready = 0; i_dat0 = 32'hA;
    step(); step();          // o_valid is set and i_ready low: request stalls
    @(negedge i_clk);
    check("stats_stall", 64'(o_stall), 64'(1));
    i_ready = 1;
    step(); step(); i_req0 = 0;
    @(negedge i_clk);
    check("stats_cnt1", 64'(o_cnt1), 64'(5));
    check("stats_cnt0", 64'(o_cnt0), 64'(2));
`endif

    // Randomized traffic; producers hold requests until acked, with occasional early withdrawal.
    rst_pending = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge i_clk); a0 = o_ack0; a1 = o_ack1;
      step();
      if (rst_pending) begin i_rst_n = 1'b1; rst_pending = 0; end
      if (!i_req0 || a0 || $urandom_range(0, 15) == 0) begin
        i_req0 = $urandom_range(0, 2) != 0; i_dat0 = $urandom;
      end
      if (!i_req1 || a1 || $urandom_range(0, 15) == 0) begin
        i_req1 = $urandom_range(0, 2) != 0; i_dat1 = $urandom;
      end
      i_ready = $urandom_range(0, 3) != 0;
      if ($urandom_range(0, 499) == 0) begin i_rst_n = 1'b0; rst_pending = 1; end
    end
    i_rst_n = 1'b1; i_req0 = 0; i_req1 = 0;
    step(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
